// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle CPU: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives every datapath select, write enable and ALU op from the state register.
module multi_cycle_ctrl #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       ior,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal,
  output logic       halted
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    AIEX   = 4'd9,
    AIWB   = 4'd10,
    JMP    = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] rtype_op;
  logic       rtype_ok;
  logic       pc_write, branch;

  always_comb begin
    rtype_ok = 1'b1;
    rtype_op = 3'b010;
    case (funct)
      6'b100000: rtype_op = 3'b010;
      6'b100010: rtype_op = 3'b110;
      6'b100100: rtype_op = 3'b000;
      6'b100101: rtype_op = 3'b001;
      6'b101010: rtype_op = 3'b111;
      default:   rtype_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = FETCH;
    illegal_d = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW)         state_d = MEMADR;
        else if (opcode == OP_RTYPE && rtype_ok)        state_d = REX;
        else if (opcode == OP_BEQ)                      state_d = BEQ;
        else if (opcode == OP_ADDI)                     state_d = AIEX;
        else if (opcode == OP_J)                        state_d = JMP;
        else begin
          illegal_d = 1'b1;
          state_d   = ILLEGAL_TRAP ? HALT : FETCH;
        end
      end
      MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = MEMWB;
      REX:    state_d = RWB;
      AIEX:   state_d = AIWB;
      HALT:   state_d = HALT;
      default: state_d = FETCH;  // terminal states and unused encodings 13-15
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    ior        = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = 3'b010;
    pc_source  = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR, AIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        ior      = 1'b1;
        mem_read = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        ior       = 1'b1;
        mem_write = 1'b1;
      end
      REX: begin
        alu_src_a = 1'b1;
        alu_ctrl  = rtype_op;
      end
      RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BEQ: begin
        alu_src_a = 1'b1;
        alu_ctrl  = 3'b110;
        pc_source = 2'b01;
        branch    = 1'b1;
      end
      AIWB: reg_write = 1'b1;
      JMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    pc_en = pc_write | (branch & zero);
    // Reset abandons the instruction in flight: no architectural write may land.
    if (rst) begin
      pc_en     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign halted  = (state_q == HALT);

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Main control FSM of the multi-cycle CPU; sits directly upstream of the datapath registers (PC, IR, MDR, A/B, ALUOut).
- Decodes opcode/funct from the IR and sequences the FETCH/DECODE/EXEC/MEM/WB steps.
- Drives every mux select, write enable and ALU operation in the datapath.
- Supports add, sub, and, or, slt, lw, sw, beq, addi and j; flags unsupported encodings.

Parameters:
- ILLEGAL_TRAP, 0: 0 = an illegal instruction pulses `illegal` and resumes at FETCH; 1 = the FSM enters HALT and stays there until reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- opcode  input  6  IR[31:26].
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag, same cycle.
- pc_en  output  1  PC write enable = pc_write | (branch & zero).
- ior  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load enable.
- reg_dst  output  1  register write address: 0 = rt, 1 = rd.
- mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A: 0 = PC, 1 = A register.
- alu_src_b  output  2  ALU B: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_ctrl  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump address.
- state  output  4  current state encoding, for debug.
- illegal  output  1  one-cycle pulse on an illegal instruction.
- halted  output  1  high while in HALT.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQ=8, AIEX=9, AIWB=10, JMP=11, HALT=12.
- Moore outputs decode from the state register; pc_en also depends combinationally on zero.
- Any output not listed for a state is 0, except alu_ctrl, which defaults to 010.
- Reset:
  - On a posedge with rst=1: state<=FETCH, illegal<=0.
  - While rst=1, pc_en, mem_read, mem_write, ir_write and reg_write are forced to 0 regardless of state.
  - Reset mid-instruction abandons it with no further writes; after rst falls, the next edge begins FETCH.
- Per-state outputs:
  - FETCH: mem_read=1, ior=0, ir_write=1, alu_src_a=0, alu_src_b=01, add, pc_source=00, pc_write=1.
  - DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut).
  - MEMADR: alu_src_a=1, alu_src_b=10, add.
  - MEMRD: ior=1, mem_read=1.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - MEMWR: ior=1, mem_write=1.
  - REX: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt).
  - RWB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - BEQ: alu_src_a=1, alu_src_b=00, sub, pc_source=01, branch=1.
  - AIEX: alu_src_a=1, alu_src_b=10, add.
  - AIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - JMP: pc_source=10, pc_write=1.
  - HALT: all enables 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE by opcode: 100011/101011 -> MEMADR; 000000 with a supported funct -> REX; 000100 -> BEQ; 001000 -> AIEX; 000010 -> JMP.
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD->MEMWB; REX->RWB; AIEX->AIWB.
  - MEMWB, MEMWR, RWB, BEQ, AIWB and JMP return to FETCH.
  - HALT->HALT.
- Illegal instruction:
  - Any other opcode, or opcode 000000 with an unsupported funct, in DECODE is illegal.
  - The FSM goes to FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1).
  - illegal is registered high for exactly the one following cycle.
- Timing:
  - opcode and funct are sampled only in DECODE and later states; IR is stable because ir_write=0 outside FETCH.
  - Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Unused state encodings 13–15 go to FETCH on the next edge, with all outputs 0 while in them.

Test Plan:
- Reset: hold rst=1 for 3 cycles with any opcode -> state=0, all write enables 0 during reset, illegal=0; first cycle after release shows FETCH outputs (mem_read=1, ir_write=1, pc_en=1, alu_src_b=01).
- lw (opcode 100011): state trace 0,1,2,3,4,0; MEMRD shows ior=1, mem_read=1; MEMWB shows reg_write=1, mem_to_reg=1, reg_dst=0.
- R-type:
  - sub (opcode 0, funct 100010): trace 0,1,6,7,0, alu_ctrl=110 in REX, reg_dst=1 in RWB.
  - slt: alu_ctrl=111 in REX.
- beq (000100): zero=1 in BEQ -> pc_en=1, pc_source=01; zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
- Illegal (opcode 111111):
  - ILLEGAL_TRAP=0 -> DECODE->FETCH, illegal high exactly 1 cycle.
  - ILLEGAL_TRAP=1 -> state=12, halted=1 and held for 20 cycles; rst releases it to FETCH.
- Reset mid-operation: assert rst in MEMWR during sw -> mem_write drops to 0 in the same cycle; state=0 after the edge.
